multiciclo_ctrl: RTL and testbench

Multicycle control FSM that sequences the RV64 integer datapath (instruction memory, register file, sign extend, ALU) over several clocks per instruction. It replaces the purely combinational opcode decoder and fixed PC+4 every cycle. The block fetches through a shared instruction/data memory port with a req/ack handshake and gates every architectural write-enable. It stops in a halt state on illegal opcodes or memory timeouts.

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/multiciclo_ctrl_ack_timer.sv | 28 ++
 rtl/multiciclo_ctrl.sv | 158 +++++++++++++++
 tb/tb_multiciclo_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared opcode, state and fault definitions for the multicycle RV64 controller.
package riscv_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd7
  } state_e;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  function automatic logic opc_legal(input logic [6:0] opc);
    return (opc == OPC_OP) || (opc == OPC_OPIMM) ||
           (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

endpackage

// File: rtl/multiciclo_ctrl_ack_timer.sv
// Memory acknowledge watchdog: counts unacknowledged request cycles and flags
// the cycle in which the count would reach LIMIT without an ack.
module ack_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 8'd0;
    end else if (clr) begin
      cnt_q <= 8'd0;
    end else if (inc) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  // An ack in the limit cycle deasserts inc, so the ack takes priority.
  assign expired = inc && (cnt_q == 8'(LIMIT - 1));

endmodule

// File: rtl/multiciclo_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV64 integer datapath.
// Optional performance counters are enabled with MULTICICLO_PERFCNT_EN.
//   state  | meaning
//   FETCH  | instruction read request, load IR and bump PC on ack
//   DECODE | operands settle, opcode latched, illegal opcode halts
//   EXEC   | ALU operates, operand 2 select driven
//   MEM    | data read/write request until ack
//   WB     | single-cycle register file write
//   HALT   | stopped on fault, left only through reset
module multiciclo_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [6:0]  opcode_i,
  input  logic        mem_ack_i,
  output logic        mem_req_o,
  output logic        mem_sel_o,
  output logic        mem_we_o,
  output logic        ir_we_o,
  output logic        pc_we_o,
  output logic        alusrc_o,
  output logic        wbsel_o,
  output logic        regwrite_o,
  output logic        halt_o,
  output logic [1:0]  fault_o,
  output logic [2:0]  state_o
`ifdef MULTICICLO_PERFCNT_EN
  ,
  output logic [31:0] cycles_o,
  output logic [31:0] retired_o
`endif
);

  state_e     state_q, state_d;
  logic [6:0] opc_q;
  logic [1:0] fault_q, fault_d;
  logic       req_int;
  logic       expired;
  logic       ir_we_c, pc_we_c, sel_c, we_c, alusrc_c, wbsel_c, regwrite_c;

  assign req_int = (state_q == ST_FETCH) || (state_q == ST_MEM);

  ack_timer #(.LIMIT(ACK_TIMEOUT)) u_ack_timer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr     (!req_int || mem_ack_i),
    .inc     (req_int && !mem_ack_i),
    .expired (expired)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_FETCH;
      fault_q <= FAULT_NONE;
      opc_q   <= 7'd0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      if (state_q == ST_DECODE) opc_q <= opcode_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    fault_d    = fault_q;
    ir_we_c    = 1'b0;
    pc_we_c    = 1'b0;
    sel_c      = 1'b0;
    we_c       = 1'b0;
    alusrc_c   = 1'b0;
    wbsel_c    = 1'b0;
    regwrite_c = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (mem_ack_i) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = ST_DECODE;
        end else if (expired) begin
          state_d = ST_HALT;
          fault_d = FAULT_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (!opc_legal(opcode_i)) begin
          state_d = ST_HALT;
          fault_d = FAULT_ILLEGAL;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alusrc_c = (opc_q != OPC_OP);
        state_d  = ((opc_q == OPC_LOAD) || (opc_q == OPC_STORE)) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        sel_c = 1'b1;
        we_c  = (opc_q == OPC_STORE);
        if (mem_ack_i) begin
          state_d = (opc_q == OPC_STORE) ? ST_FETCH : ST_WB;
        end else if (expired) begin
          state_d = ST_HALT;
          fault_d = FAULT_TIMEOUT;
        end
      end
      ST_WB: begin
        regwrite_c = 1'b1;
        wbsel_c    = (opc_q == OPC_LOAD);
        state_d    = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  // Reset holds state at FETCH, so the request and fetch strobes are gated
  // by rst_ni to drop them asynchronously while reset is asserted.
  assign mem_req_o  = req_int && rst_ni;
  assign ir_we_o    = ir_we_c && rst_ni;
  assign pc_we_o    = pc_we_c && rst_ni;
  assign mem_sel_o  = sel_c;
  assign mem_we_o   = we_c;
  assign alusrc_o   = alusrc_c;
  assign wbsel_o    = wbsel_c;
  assign regwrite_o = regwrite_c;
  assign halt_o     = (state_q == ST_HALT);
  assign fault_o    = fault_q;
  assign state_o    = state_q;

`ifdef MULTICICLO_PERFCNT_EN
  logic [31:0] cycles_q, retired_q;
  logic        retire;

  assign retire = (state_q == ST_WB) ||
                  ((state_q == ST_MEM) && (state_d == ST_FETCH));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycles_q  <= 32'd0;
      retired_q <= 32'd0;
    end else if (state_q != ST_HALT) begin
      cycles_q <= cycles_q + 32'd1;
      if (retire) retired_q <= retired_q + 32'd1;
    end
  end

  assign cycles_o  = cycles_q;
  assign retired_o = retired_q;
`endif

endmodule

// File: tb/tb_multiciclo_ctrl.sv
// Directed, table-driven bench for multiciclo_ctrl with ACK_TIMEOUT=4.
module tb_multiciclo_ctrl;

  localparam logic [6:0] OP    = 7'b0110011;
  localparam logic [6:0] OPIMM = 7'b0010011;
  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] ILL   = 7'b1111111;

  // {req,sel,we,ir_we,pc_we,alusrc,wbsel,regwrite,halt}
  localparam logic [8:0] O_NONE   = 9'b000000000;
  localparam logic [8:0] O_F_ACK  = 9'b100110000;
  localparam logic [8:0] O_F_WAIT = 9'b100000000;
  localparam logic [8:0] O_EX_IMM = 9'b000001000;
  localparam logic [8:0] O_WB_ALU = 9'b000000010;
  localparam logic [8:0] O_WB_LD  = 9'b000000110;
  localparam logic [8:0] O_MEM_RD = 9'b110000000;
  localparam logic [8:0] O_MEM_WR = 9'b111000000;
  localparam logic [8:0] O_HALT   = 9'b000000001;

  typedef struct {
    logic       rst;
    logic       ack;
    logic [6:0] opc;
    logic [2:0] st;
    logic [8:0] outs;
    logic [1:0] fault;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = OP;
  logic        ack = 1'b0;
  logic        mem_req, mem_sel, mem_we, ir_we, pc_we, alusrc, wbsel, regwrite, halt;
  logic [1:0]  fault;
  logic [2:0]  state;
`ifdef MULTICICLO_PERFCNT_EN
  logic [31:0] cycles, retired;
`endif

  int errors = 0;
  int checks = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  multiciclo_ctrl #(.ACK_TIMEOUT(4)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .opcode_i   (opcode),
    .mem_ack_i  (ack),
    .mem_req_o  (mem_req),
    .mem_sel_o  (mem_sel),
    .mem_we_o   (mem_we),
    .ir_we_o    (ir_we),
    .pc_we_o    (pc_we),
    .alusrc_o   (alusrc),
    .wbsel_o    (wbsel),
    .regwrite_o (regwrite),
    .halt_o     (halt),
    .fault_o    (fault),
    .state_o    (state)
`ifdef MULTICICLO_PERFCNT_EN
    ,
    .cycles_o   (cycles),
    .retired_o  (retired)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic a, input logic [6:0] o,
                     input logic [2:0] s, input logic [8:0] e, input logic [1:0] f);
    vq.push_back('{rst: r, ack: a, opc: o, st: s, outs: e, fault: f});
  endtask

  initial begin
    // reset held
    add(0, 1, OP, 0, O_NONE, 0);
    add(0, 1, OP, 0, O_NONE, 0);
    // OP, zero wait: 0,1,2,4,0
    add(1, 1, OP, 0, O_F_ACK, 0);
    add(1, 1, OP, 1, O_NONE, 0);
    add(1, 1, OP, 2, O_NONE, 0);
    add(1, 1, OP, 4, O_WB_ALU, 0);
    // OP-IMM; opcode_i corrupted after DECODE must not matter
    add(1, 1, OPIMM, 0, O_F_ACK, 0);
    add(1, 1, OPIMM, 1, O_NONE, 0);
    add(1, 1, ILL, 2, O_EX_IMM, 0);
    add(1, 1, ILL, 4, O_WB_ALU, 0);
    // LOAD with 3 wait cycles in MEM: 8 cycles
    add(1, 1, LOAD, 0, O_F_ACK, 0);
    add(1, 1, LOAD, 1, O_NONE, 0);
    add(1, 0, LOAD, 2, O_EX_IMM, 0);
    add(1, 0, OP, 3, O_MEM_RD, 0);
    add(1, 0, OP, 3, O_MEM_RD, 0);
    add(1, 0, OP, 3, O_MEM_RD, 0);
    add(1, 1, OP, 3, O_MEM_RD, 0);
    add(1, 1, OP, 4, O_WB_LD, 0);
    // STORE with one wait cycle
    add(1, 1, STORE, 0, O_F_ACK, 0);
    add(1, 1, STORE, 1, O_NONE, 0);
    add(1, 1, STORE, 2, O_EX_IMM, 0);
    add(1, 0, STORE, 3, O_MEM_WR, 0);
    add(1, 1, STORE, 3, O_MEM_WR, 0);
    // FETCH ack on 4th cycle: ack wins over timeout
    add(1, 0, ILL, 0, O_F_WAIT, 0);
    add(1, 0, ILL, 0, O_F_WAIT, 0);
    add(1, 0, ILL, 0, O_F_WAIT, 0);
    add(1, 1, ILL, 0, O_F_ACK, 0);
    // illegal opcode
    add(1, 1, ILL, 1, O_NONE, 0);
    add(1, 1, ILL, 7, O_HALT, 1);
    for (int i = 0; i < 20; i++) add(1, logic'(i % 2), OP, 7, O_HALT, 1);
    // reset clears halt, then timeout in FETCH
    add(0, 0, OP, 0, O_NONE, 0);
    add(1, 0, OP, 0, O_F_WAIT, 0);
    add(1, 0, OP, 0, O_F_WAIT, 0);
    add(1, 0, OP, 0, O_F_WAIT, 0);
    add(1, 0, OP, 0, O_F_WAIT, 0);
    add(1, 0, OP, 7, O_HALT, 2);
    add(1, 1, OP, 7, O_HALT, 2);

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk);
      #1;
      rst_n  = vq[i].rst;
      ack    = vq[i].ack;
      opcode = vq[i].opc;
      #3;
      chk($sformatf("v%0d state", i), 32'(state), 32'(vq[i].st));
      chk($sformatf("v%0d outs", i),
          32'({mem_req, mem_sel, mem_we, ir_we, pc_we, alusrc, wbsel, regwrite, halt}),
          32'(vq[i].outs));
      chk($sformatf("v%0d fault", i), 32'(fault), 32'(vq[i].fault));
      chk($sformatf("v%0d rw_we_excl", i), 32'(regwrite & mem_we), 32'd0);
    end

    // reset during a store's MEM phase
    @(posedge clk); #1; rst_n = 0;
    @(posedge clk); #1; rst_n = 1; ack = 1; opcode = STORE;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1; ack = 0;
    #1;
    chk("mid_mem state", 32'(state), 32'd3);
    chk("mid_mem req/we", 32'({mem_req, mem_we}), 32'b11);
    #1; rst_n = 0;
    #1;
    chk("async rst req/we", 32'({mem_req, mem_we, mem_sel}), 32'b000);
    chk("async rst state", 32'(state), 32'd0);
    @(posedge clk); #1; rst_n = 1; ack = 1; opcode = OP;
    #1;
    chk("release state", 32'(state), 32'd0);
    chk("release req", 32'(mem_req), 32'd1);

`ifdef MULTICICLO_PERFCNT_EN
    @(posedge clk); #1; rst_n = 0;
    #1;
    chk("perf rst cycles", cycles, 32'd0);
    @(posedge clk); #1; rst_n = 1; ack = 1; opcode = OP;
    repeat (12) @(posedge clk);
    #1;
    chk("perf retired", retired, 32'd3);
    chk("perf cycles", cycles, 32'd12);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
